// File: rtl/pwm_audio_pkg.sv
// rtl/pwm_audio_pkg.sv - shared ramp state type, default period constants and level conversion
// for pwm_audio_out.
package pwm_audio_pkg;

  typedef enum logic [1:0] {
    UNMUTED   = 2'd0,
    RAMP_DOWN = 2'd1,
    MUTED     = 2'd2,
    RAMP_UP   = 2'd3
  } ramp_state_t;

  localparam int DEF_PWM_WIDTH = 8;
  localparam int PERIOD        = 2 ** DEF_PWM_WIDTH;
  localparam int MIDSCALE      = PERIOD / 2;

  // Signed scaled sample -> offset-binary PWM level: inverted sign bit on top,
  // followed by the next pwm_width-1 magnitude bits.
  function automatic logic [31:0] to_offset_level(input logic [63:0] scaled,
                                                  input int in_width,
                                                  input int pwm_width);
    logic [63:0] shifted;
    logic [63:0] mask;
    logic [63:0] sign_bit;
    logic [31:0] lvl;
    shifted  = scaled >> (in_width - pwm_width);
    mask     = (64'd1 << (pwm_width - 1)) - 64'd1;
    sign_bit = (scaled >> (in_width - 1)) & 64'd1;
    lvl      = shifted[31:0] & mask[31:0];
    if (sign_bit == 64'd0) begin
      lvl = lvl | (32'd1 << (pwm_width - 1));
    end
    return lvl;
  endfunction

endpackage

// File: rtl/pwm_audio_chan.sv
// rtl/pwm_audio_chan.sv - one PWM channel: volume shift, shadow/active level registers and
// the duty comparator.
module pwm_audio_chan
  import pwm_audio_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int PWM_WIDTH = DEF_PWM_WIDTH,
  parameter int SH_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  sample,
  input  logic [SH_W-1:0]      shift,
  input  logic                 capture,
  input  logic                 transfer,
  input  logic                 force_mid,
  input  logic [PWM_WIDTH-1:0] count,
  output logic                 pwm
);

  localparam logic [PWM_WIDTH-1:0] MID_LEVEL = {1'b1, {(PWM_WIDTH-1){1'b0}}};

  logic signed [IN_WIDTH-1:0] scaled;
  logic [PWM_WIDTH-1:0]       level;
  logic [PWM_WIDTH-1:0]       shadow;
  logic [PWM_WIDTH-1:0]       active;

  always_comb begin
    scaled = $signed(sample) >>> shift;
    level  = PWM_WIDTH'(to_offset_level(64'(scaled), IN_WIDTH, PWM_WIDTH));
  end

  // The active level only changes at the period boundary, so a duty cycle is never split.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow <= MID_LEVEL;
      active <= MID_LEVEL;
      pwm    <= 1'b0;
    end else begin
      if (capture) begin
        shadow <= level;
      end
      if (transfer) begin
        active <= force_mid ? MID_LEVEL : shadow;
      end
      pwm <= (count < active);
    end
  end

endmodule

// File: rtl/pwm_audio_out.sv
// rtl/pwm_audio_out.sv - multi-channel PWM audio output stage with volume, mute and overrun.
// Define SOFT_MUTE_EN for a ramped (stepwise attenuated) mute instead of an immediate one.
module pwm_audio_out
  import pwm_audio_pkg::*;
#(
  parameter int IN_WIDTH     = 16,
  parameter int PWM_WIDTH    = DEF_PWM_WIDTH,
  parameter int NUM_CH       = 2,
  parameter int VOL_WIDTH    = 3,
  parameter int RAMP_PERIODS = 64
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic [NUM_CH*IN_WIDTH-1:0] sample_in,
  input  logic                       sample_valid_in,
  input  logic [VOL_WIDTH-1:0]       vol_in,
  input  logic                       mute_in,
  output logic [NUM_CH-1:0]          pwm_out,
  output logic                       period_start_out,
  output logic                       overrun_out,
  output logic                       mute_active_out
);

  localparam int                   MAX_VOL = 2 ** VOL_WIDTH - 1;
  localparam int                   SH_W    = $clog2(IN_WIDTH);
  localparam logic [PWM_WIDTH-1:0] CNT_MAX = '1;

  if (PWM_WIDTH > IN_WIDTH || PWM_WIDTH < 2 || RAMP_PERIODS < 1) begin : g_bad_params
    $error("pwm_audio_out: invalid PWM_WIDTH/IN_WIDTH/RAMP_PERIODS combination");
  end

  logic [PWM_WIDTH-1:0] count;
  logic                 transfer;
  logic                 shadow_full;
  logic                 force_mid;
  logic                 mute_active;
  logic [SH_W-1:0]      att;
  logic [SH_W-1:0]      shift;
  int                   shift_sum;

  assign transfer        = (count == CNT_MAX);
  assign mute_active_out = mute_active;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      count            <= '0;
      period_start_out <= 1'b0;
      shadow_full      <= 1'b0;
      overrun_out      <= 1'b0;
    end else begin
      count            <= count + PWM_WIDTH'(1);
      period_start_out <= transfer;
      // A capture in the transfer cycle wins: it waits in the shadow for the next period.
      if (sample_valid_in) begin
        shadow_full <= 1'b1;
        if (shadow_full) begin
          overrun_out <= 1'b1;
        end
      end else if (transfer) begin
        shadow_full <= 1'b0;
      end
    end
  end

`ifdef SOFT_MUTE_EN
  localparam int RC_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

  ramp_state_t     state;
  logic [RC_W-1:0] ramp_cnt;
  logic            ramping;
  logic            ramp_step;

  assign ramping     = (state == RAMP_DOWN) || (state == RAMP_UP);
  assign ramp_step   = transfer && (ramp_cnt == RC_W'(RAMP_PERIODS - 1));
  assign mute_active = (state == MUTED);
  assign force_mid   = (state == MUTED);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state    <= UNMUTED;
      att      <= '0;
      ramp_cnt <= '0;
    end else begin
      if (!ramping) begin
        ramp_cnt <= '0;
      end else if (transfer) begin
        ramp_cnt <= ramp_step ? '0 : ramp_cnt + RC_W'(1);
      end
      // Direction reversals keep the current attenuation and continue from there.
      case (state)
        UNMUTED: begin
          if (mute_in) state <= RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (!mute_in) begin
            state <= RAMP_UP;
          end else if (ramp_step) begin
            att <= att + SH_W'(1);
            if (att == SH_W'(IN_WIDTH - 2)) state <= MUTED;
          end
        end
        MUTED: begin
          if (!mute_in) state <= RAMP_UP;
        end
        RAMP_UP: begin
          if (mute_in) begin
            state <= RAMP_DOWN;
          end else if (att == '0) begin
            state <= UNMUTED;
          end else if (ramp_step) begin
            att <= att - SH_W'(1);
            if (att == SH_W'(1)) state <= UNMUTED;
          end
        end
        default: state <= UNMUTED;
      endcase
    end
  end
`else
  assign att       = '0;
  assign force_mid = mute_in;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      mute_active <= 1'b0;
    end else if (transfer) begin
      mute_active <= mute_in;
    end
  end
`endif

  always_comb begin
    shift_sum = MAX_VOL - int'(vol_in) + int'(att);
    if (shift_sum > IN_WIDTH - 1) begin
      shift_sum = IN_WIDTH - 1;
    end
    shift = SH_W'(shift_sum);
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    pwm_audio_chan #(
      .IN_WIDTH (IN_WIDTH),
      .PWM_WIDTH(PWM_WIDTH),
      .SH_W     (SH_W)
    ) u_chan (
      .clk      (clk_in),
      .rst_n    (rst_n_in),
      .sample   (sample_in[c*IN_WIDTH +: IN_WIDTH]),
      .shift    (shift),
      .capture  (sample_valid_in),
      .transfer (transfer),
      .force_mid(force_mid),
      .count    (count),
      .pwm      (pwm_out[c])
    );
  end

endmodule
